// File: rtl/load_unit_if.sv
// load_unit_if: request, data-memory and peripheral read channels of the load unit.
interface load_unit_if;
  logic ld_req;
  logic [31:0] A;
  logic [2:0] DMOp;
  logic ld_signed;
  logic M_EXC_DMOv;
  logic flush;
  logic m_rd_en;
  logic [31:0] m_rd_addr;
  logic [31:0] m_data_rdata;
  logic dev_req;
  logic [31:0] dev_addr;
  logic [31:0] dev_rdata;
  logic dev_rvalid;
  logic ld_busy;
  logic ld_done;
  logic [31:0] ld_data;
  logic ld_adel;
  logic ld_timeout;
  modport master (
    output ld_req, A, DMOp, ld_signed, M_EXC_DMOv, flush, m_data_rdata, dev_rdata, dev_rvalid,
    input m_rd_en, m_rd_addr, dev_req, dev_addr, ld_busy, ld_done, ld_data, ld_adel, ld_timeout
  );
  modport slave (
    input ld_req, A, DMOp, ld_signed, M_EXC_DMOv, flush, m_data_rdata, dev_rdata, dev_rvalid,
    output m_rd_en, m_rd_addr, dev_req, dev_addr, ld_busy, ld_done, ld_data, ld_adel, ld_timeout
  );
endinterface

// File: rtl/load_unit.sv
// load_unit: multi-cycle load FSM for data memory and peripherals with alignment checks and timeout.
module load_unit (
  input logic clk,
  input logic reset,
  load_unit_if.slave bus
);
  typedef enum logic [1:0] {IDLE, DMW, DEVW, EXC} state_t;
  state_t state, state_n;
  logic [3:0] cnt;
  logic [1:0] off;
  logic [2:0] op;
  logic sgn;
  logic [31:0] dev_addr_q, data_q;
  logic done_q, adel_q, tmo_q;
  logic is_h, is_b, in_dm, in_tc, in_ig, adel, accept, tmo;
  function automatic logic [31:0] ext(input logic [31:0] d, input logic [1:0] o, input logic [2:0] p, input logic s);
    logic [15:0] h;
    logic [7:0] b;
    h = o[1] ? d[31:16] : d[15:0];
    b = o[0] ? h[15:8] : h[7:0];
    return p == 3'b001 ? {{16{s & h[15]}}, h} : p == 3'b010 ? {{24{s & b[7]}}, b} : d;
  endfunction
  always_comb begin
    is_h = bus.DMOp == 3'b001;
    is_b = bus.DMOp == 3'b010;
    in_dm = bus.A < 32'h0000_3000;
    in_tc = (bus.A >= 32'h0000_7F00 && bus.A <= 32'h0000_7F0B) || (bus.A >= 32'h0000_7F10 && bus.A <= 32'h0000_7F1B);
    in_ig = bus.A >= 32'h0000_7F20 && bus.A <= 32'h0000_7F23;
    adel = bus.M_EXC_DMOv || (!is_h && !is_b && bus.A[1:0] != 2'b00) || (is_h && bus.A[0]) ||
           !(in_dm || in_tc || in_ig) || ((is_h || is_b) && in_tc);
    accept = state == IDLE && bus.ld_req && !bus.flush && !reset;
    tmo = state == DEVW && !bus.dev_rvalid && cnt == 4'hF;
    state_n = bus.flush ? IDLE :
              state == IDLE ? (bus.ld_req ? (adel ? EXC : in_dm ? DMW : DEVW) : IDLE) :
              state == DEVW && !bus.dev_rvalid && cnt != 4'hF ? DEVW : IDLE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt <= 4'd0;
      data_q <= 32'h0;
      done_q <= 1'b0;
      adel_q <= 1'b0;
      tmo_q <= 1'b0;
      off <= 2'b00;
      op <= 3'b000;
      sgn <= 1'b0;
      dev_addr_q <= 32'h0;
    end else begin
      state <= state_n;
      cnt <= state == DEVW ? cnt + 4'd1 : 4'd0;
      // an address error completes immediately so its pulse lines up with the EXC cycle
      done_q <= !bus.flush && ((accept && adel) || state == DMW || (state == DEVW && (bus.dev_rvalid || cnt == 4'hF)));
      adel_q <= accept && adel;
      tmo_q <= !bus.flush && tmo;
      if (accept) begin
        off <= bus.A[1:0];
        op <= bus.DMOp;
        sgn <= bus.ld_signed;
        dev_addr_q <= bus.A;
      end
      if (!bus.flush && state == DMW)
        data_q <= ext(bus.m_data_rdata, off, op, sgn);
      else if (!bus.flush && state == DEVW && bus.dev_rvalid)
        data_q <= ext(bus.dev_rdata, off, op, sgn);
    end
  end
  assign bus.m_rd_en = accept && !adel && in_dm;
  assign bus.m_rd_addr = {bus.A[31:2], 2'b00};
  assign bus.dev_req = state == DEVW && !reset;
  assign bus.dev_addr = dev_addr_q;
  assign bus.ld_busy = state != IDLE && !reset;
  assign bus.ld_done = done_q;
  assign bus.ld_data = data_q;
  assign bus.ld_adel = adel_q;
  assign bus.ld_timeout = tmo_q;
endmodule
